// File: rtl/scmp_ifetch_if.sv
// Memory read bus between the SC/MP instruction fetcher and the memory system.
interface scmp_ifetch_if;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_ack;
  logic [7:0]  bus_din;

  modport master (output bus_addr, bus_rd, input bus_ack, bus_din);
  modport slave  (input bus_addr, bus_rd, output bus_ack, bus_din);
endinterface

// File: rtl/scmp_ifetch.sv
// SC/MP instruction fetcher: pre-increments P0 within its 4 KB page, reads the
// opcode and (for two-byte instructions) the displacement, then pulses op_valid.
module scmp_ifetch (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [15:0]          pc_in,
  output logic [15:0]          pc_out,
  output logic                 pc_we,
  scmp_ifetch_if.master        bus,
  output logic [7:0]           op,
  output logic [7:0]           disp,
  output logic                 op_valid,
  output logic                 busy
);

  localparam int unsigned PC_W   = 16;
  localparam int unsigned OFFS_W = 12;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INC1 = 3'd1,
    S_RD1  = 3'd2,
    S_INC2 = 3'd3,
    S_RD2  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt;
  logic [BYTE_W-1:0]   op_nxt, disp_nxt;
  logic                bus_rd_q;

  // Increment confined to the 4 KB page; the page bits never change.
  function automatic logic [PC_W-1:0] page_inc(input logic [PC_W-1:0] a);
    page_inc = {a[PC_W-1:OFFS_W], a[OFFS_W-1:0] + OFFS_W'(1)};
  endfunction

  // Next-state and datapath. The increment is loaded on the edge entering an
  // INC state so pc_out already shows the new P0 while pc_we is high.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    op_nxt    = op;
    disp_nxt  = disp;
    case (state)
      S_IDLE: begin
        if (fetch_req) begin
          pc_nxt    = page_inc(pc_in);
          state_nxt = S_INC1;
        end
      end
      S_INC1: state_nxt = S_RD1;
      S_RD1: begin
        if (bus.bus_ack) begin
          op_nxt = bus.bus_din;
          if (bus.bus_din[BYTE_W-1]) begin
            pc_nxt    = page_inc(pc);
            state_nxt = S_INC2;
          end else begin
            disp_nxt  = BYTE_W'(0);
            state_nxt = S_DONE;
          end
        end
      end
      S_INC2: state_nxt = S_RD2;
      S_RD2: begin
        if (bus.bus_ack) begin
          disp_nxt  = bus.bus_din;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= PC_W'(0);
      op       <= BYTE_W'(0);
      disp     <= BYTE_W'(0);
      pc_we    <= 1'b0;
      bus_rd_q <= 1'b0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      op       <= op_nxt;
      disp     <= disp_nxt;
      pc_we    <= (state_nxt == S_INC1) || (state_nxt == S_INC2);
      bus_rd_q <= (state_nxt == S_RD1) || (state_nxt == S_RD2);
      op_valid <= (state_nxt == S_DONE);
      busy     <= (state_nxt != S_IDLE);
    end
  end

  assign pc_out       = pc;
  assign bus.bus_addr = pc;
  assign bus.bus_rd   = bus_rd_q;

endmodule

// File: tb/tb_scmp_ifetch.sv
// Bench for scmp_ifetch: a transaction-level trace model expanded at each
// accepted fetch, compared every cycle, plus directed literal expectations.
module tb_scmp_ifetch;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [15:0] pc_in;
  logic [15:0] pc_out;
  logic        pc_we;
  logic [7:0]  op;
  logic [7:0]  disp;
  logic        op_valid;
  logic        busy;

  scmp_ifetch_if bus_if();

  scmp_ifetch dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .pc_we     (pc_we),
    .bus       (bus_if),
    .op        (op),
    .disp      (disp),
    .op_valid  (op_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_we;
    logic [15:0] pc_out;
    logic        rd;
    logic [15:0] addr;
    logic        ov;
    logic        busy;
    logic [7:0]  op;
    logic [7:0]  disp;
  } exp_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mem [0:65535];
  int          cfg_w1 = 0;
  int          cfg_w2 = 0;
  bit          ack_force = 1'b0;
  int          rd_num = 0;
  int          wcnt = 0;

  exp_t        q[$];
  logic [15:0] m_pc = 16'h0000;
  logic [7:0]  m_op = 8'h00;
  logic [7:0]  m_disp = 8'h00;

  logic [15:0] pcwe_log[$];
  logic [15:0] rd_log[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pinc(input logic [15:0] a);
    logic [11:0] o;
    o = a[11:0] + 12'd1;
    return {a[15:12], o};
  endfunction

  // Expand one fetch into its expected per-cycle output trace.
  task automatic build(input logic [15:0] pc0);
    logic [15:0] a, b;
    logic [7:0]  b0, b1;
    a  = pinc(pc0);
    b0 = mem[a];
    q.push_back('{1'b1, a, 1'b0, a, 1'b0, 1'b1, m_op, m_disp});
    for (int i = 0; i <= cfg_w1; i++) q.push_back('{1'b0, a, 1'b1, a, 1'b0, 1'b1, m_op, m_disp});
    if (b0[7]) begin
      b  = pinc(a);
      b1 = mem[b];
      q.push_back('{1'b1, b, 1'b0, b, 1'b0, 1'b1, b0, m_disp});
      for (int i = 0; i <= cfg_w2; i++) q.push_back('{1'b0, b, 1'b1, b, 1'b0, 1'b1, b0, m_disp});
      q.push_back('{1'b0, b, 1'b0, b, 1'b1, 1'b1, b0, b1});
      m_pc   = b;
      m_disp = b1;
    end else begin
      q.push_back('{1'b0, a, 1'b0, a, 1'b1, 1'b1, b0, 8'h00});
      m_pc   = a;
      m_disp = 8'h00;
    end
    m_op = b0;
  endtask

  // Model: the head of q is the current cycle; an empty queue means idle.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc   = 16'h0000;
      m_op   = 8'h00;
      m_disp = 8'h00;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (fetch_req) begin
      build(pc_in);
    end
  end

  // Memory responder with per-read wait states.
  always @(posedge clk) begin
    int w;
    #2;
    if (ack_force) begin
      bus_if.bus_ack = 1'b1;
      wcnt = 0;
    end else if (bus_if.bus_rd) begin
      w = (rd_num == 0) ? cfg_w1 : cfg_w2;
      if (wcnt >= w) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_din = mem[bus_if.bus_addr];
        wcnt = 0;
        rd_num++;
      end else begin
        bus_if.bus_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus_if.bus_ack = 1'b0;
      wcnt = 0;
    end
    if (!busy) rd_num = 0;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (q.size() != 0) e = q[0];
      else e = '{1'b0, m_pc, 1'b0, m_pc, 1'b0, 1'b0, m_op, m_disp};
      chk("pc_we",    16'(pc_we),          16'(e.pc_we));
      chk("pc_out",   pc_out,              e.pc_out);
      chk("bus_rd",   16'(bus_if.bus_rd),  16'(e.rd));
      chk("bus_addr", bus_if.bus_addr,     e.addr);
      chk("op_valid", 16'(op_valid),       16'(e.ov));
      chk("busy",     16'(busy),           16'(e.busy));
      chk("op",       16'(op),             16'(e.op));
      chk("disp",     16'(disp),           16'(e.disp));
      if (pc_we) pcwe_log.push_back(pc_out);
      if (bus_if.bus_rd && bus_if.bus_ack) rd_log.push_back(bus_if.bus_addr);
    end
  end

  task automatic run_fetch(input logic [15:0] pc0, input int w1, input int w2,
                           input int exp_lat, input logic [7:0] eop, input logic [7:0] edisp);
    int lat;
    pcwe_log.delete();
    rd_log.delete();
    cfg_w1    = w1;
    cfg_w2    = w2;
    pc_in     = pc0;
    fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (op_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 16'(lat), 16'(exp_lat));
    chk("op_lit", 16'(op), 16'(eop));
    chk("disp_lit", 16'(disp), 16'(edisp));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input logic [15:0] lg[$], input int n,
                         input logic [15:0] e0, input logic [15:0] e1);
    chk({name, "_n"}, 16'(lg.size()), 16'(n));
    if (lg.size() > 0) chk({name, "_0"}, lg[0], e0);
    if (n > 1 && lg.size() > 1) chk({name, "_1"}, lg[1], e1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    fetch_req = 1'b0;
    pc_in = 16'h0000;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_din = 8'h00;
    mem[16'h0101] = 8'h01;
    mem[16'h0201] = 8'hC4;
    mem[16'h0202] = 8'h55;
    mem[16'h1000] = 8'h90;
    mem[16'h1001] = 8'h12;
    mem[16'h0401] = 8'h33;
    mem[16'h0000] = 8'h7F;
    mem[16'h2AB1] = 8'h80;
    mem[16'h2AB2] = 8'hFF;
    mem[16'h0301] = 8'h05;
    mem[16'h3001] = 8'hA0;
    mem[16'h3002] = 8'h44;

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    @(posedge clk);
    #1;

    // One-byte, zero wait.
    run_fetch(16'h0100, 0, 0, 3, 8'h01, 8'h00);
    chk_log("pcwe_1b", pcwe_log, 1, 16'h0101, 16'h0000);
    chk_log("rd_1b", rd_log, 1, 16'h0101, 16'h0000);

    // Two-byte.
    run_fetch(16'h0200, 0, 0, 5, 8'hC4, 8'h55);
    chk_log("pcwe_2b", pcwe_log, 2, 16'h0201, 16'h0202);
    chk_log("rd_2b", rd_log, 2, 16'h0201, 16'h0202);

    // Page wrap at 0x1FFF.
    run_fetch(16'h1FFF, 0, 0, 5, 8'h90, 8'h12);
    chk_log("rd_wrap", rd_log, 2, 16'h1000, 16'h1001);

    // Three wait states on the opcode read.
    run_fetch(16'h0400, 3, 0, 6, 8'h33, 8'h00);

    // Wrap at 0x0FFF; displacement cleared for a one-byte opcode.
    run_fetch(16'h0FFF, 0, 0, 3, 8'h7F, 8'h00);
    chk_log("pcwe_wrap0", pcwe_log, 1, 16'h0000, 16'h0000);

    // Two-byte with waits on both reads.
    run_fetch(16'h2AB0, 1, 2, 8, 8'h80, 8'hFF);

    // bus_ack while idle is ignored.
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 ack_force = 1'b0;
    @(posedge clk);
    #1;

    // Reset during RD2, then a late ack.
    cfg_w1 = 0;
    cfg_w2 = 10;
    pc_in = 16'h3000;
    fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rd2_bus_rd", 16'(bus_if.bus_rd), 16'h0001);
    chk("rd2_addr", bus_if.bus_addr, 16'h3002);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 16'(busy), 16'h0000);
    chk("mid_rst_op", 16'(op), 16'h0000);
    chk("mid_rst_pc", pc_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 ack_force = 1'b0;
    cfg_w2 = 0;

    // Reset takes priority over fetch_req.
    rst = 1'b1;
    fetch_req = 1'b1;
    pc_in = 16'h5555;
    @(posedge clk);
    #1 rst = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("rst_pri_busy", 16'(busy), 16'h0000);
    @(posedge clk);
    #1;

    // fetch_req held high: one op_valid per fetch, no queued requests.
    pc_in = 16'h0300;
    fetch_req = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (op_valid) cnt++;
    end
    @(posedge clk);
    #1 fetch_req = 1'b0;
    chk("held_req_ovs", 16'(cnt), 16'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("final_op", 16'(op), 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scmp_ifetch.md
SCMP_IFETCH -- requirements
Module: scmp_ifetch

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have: fetch_req  input  1  microcode request to fetch next instruction; sampled in IDLE only.
REQ-004 SHALL have: pc_in  input  16  current P0 from register file; sampled on accepted fetch_req.
REQ-005 SHALL have: pc_out  output  16  incremented P0 value for register-file write-back.
REQ-006 SHALL have: pc_we  output  1  one-cycle strobe; register file writes pc_out to P0.
REQ-007 SHALL have: bus_addr  output  16  memory read address.
REQ-008 SHALL have: bus_rd  output  1  read request; held until bus_ack.
REQ-009 SHALL have: bus_ack  input  1  read complete; bus_din valid this cycle.
REQ-010 SHALL have: bus_din  input  8  read data.
REQ-011 SHALL have: op  output  8  latched opcode; drives the opcode-to-microcode-entry decoder.
REQ-012 SHALL have: disp  output  8  latched second byte (displacement/immediate).
REQ-013 SHALL have: op_valid  output  1  one-cycle pulse; op and disp stable and complete.
REQ-014 SHALL have: busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, INC1, RD1, INC2, RD2, DONE.
REQ-016 IDLE: fetch_req=1 -> internal pc register := pc_in, next state INC1; fetch_req=0 -> stay.
REQ-017 INC1 and INC2: pc := {pc[15:12], pc[11:0]+1}; pc_we=1 for exactly this one cycle, with pc_out equal to the new value; next state RD1 or RD2 respectively.
REQ-018 Increment SHALL wrap within the 4 KB page: 0x0FFF -> 0x0000, 0x1FFF -> 0x1000; bits [15:12] never change.
REQ-019 RD1 and RD2: bus_rd=1, bus_addr=pc; stay until bus_ack=1.
REQ-020 RD1 with bus_ack: op := bus_din; if bus_din[7]=1 (two-byte instruction) -> INC2, else disp := 0x00 and go to DONE.
REQ-021 RD2 with bus_ack: disp := bus_din, next state DONE.
REQ-022 DONE: op_valid=1 for one cycle, next state IDLE.
REQ-023 pc_out SHALL continuously reflect the internal pc register; pc_we is the only qualifier.
REQ-024 bus_addr SHALL equal pc in all states; bus_rd=0 outside RD1/RD2.
REQ-025 op and disp SHALL hold their values from DONE until overwritten by the next fetch.
REQ-026 fetch_req SHALL be ignored while busy=1; it is not queued.
REQ-027 Latency with bus_ack in the first RD cycle: fetch_req accepted at edge N -> op_valid high in cycle N+3 (one-byte) or N+5 (two-byte); each wait cycle adds one.
REQ-028 bus_ack outside RD1/RD2 SHALL be ignored.
REQ-029 fetch_req high in DONE SHALL be ignored; it is accepted at the first edge in IDLE.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE, pc=0x0000, op=0x00, disp=0x00, and pc_we=bus_rd=op_valid=busy=0 from the next cycle, regardless of state.
REQ-031 Reset SHALL take priority over fetch_req and bus_ack in the same cycle; a read in progress is abandoned and its late bus_ack is ignored.

Verification
REQ-032 One-byte: pc_in=0x0100, fetch_req pulse, zero-wait ack with bus_din=0x01 -> pc_we with pc_out=0x0101; bus_addr=0x0101; op=0x01, disp=0x00; op_valid at N+3.
REQ-033 Two-byte: pc_in=0x0200, data 0xC4 then 0x55 -> two pc_we strobes (0x0201, 0x0202); reads at 0x0201 and 0x0202; op=0xC4, disp=0x55; op_valid at N+5.
REQ-034 Page wrap: pc_in=0x1FFF, opcode 0x90 -> first read at 0x1000, second at 0x1001.
REQ-035 Wait states: bus_ack delayed 3 cycles in RD1 -> bus_rd and bus_addr held steady; op_valid at N+6 for a one-byte opcode.
REQ-036 Reset mid-read: rst asserted in RD2 -> next cycle IDLE with all outputs zero; a following bus_ack=1 produces no op_valid.
REQ-037 Busy ignore: fetch_req held high throughout a fetch -> exactly one op_valid per fetch, and the next fetch starts only after returning to IDLE.
